// File: rtl/matmul_load_ctrl_pkg.sv
// Shared definitions for the matrix operand loader.
//  - FSM state encodings (2 bit, legacy localparam style)
//  - err bit indices
//  - index-width and element bit-offset helpers used by the top and the shadow banks
package matmul_load_ctrl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_COMMIT = 2'd1;
  localparam logic [1:0] ST_REQ    = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  localparam int ERR_ADDR    = 0;  // write address out of range
  localparam int ERR_GO_BUSY = 1;  // go while a request is in flight
  localparam int ERR_TIMEOUT = 2;  // compute_done never arrived

  // Width of a row/column index; kept at least 1 bit so a 1-wide matrix still has a port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // LSB of element (r,c) in a row-major flat bus of m columns, w bits per element.
  function automatic int elem_lsb(input int r, input int c, input int m, input int w);
    return (r * m + c) * w;
  endfunction

endpackage

// File: rtl/matmul_load_ctrl_matrix_wr_bank.sv
// matrix_wr_bank: N x M shadow register array for one operand matrix.
//  clk, reset   : clock, asynchronous active-low reset (array clears to zero)
//  wr_en        : write strobe for this bank
//  wr_row/col   : element address
//  wr_data      : element value
//  flat         : whole array, row-major, element (r,c) at [(r*M+c)*WIDTH +: WIDTH]
//  addr_err     : high while wr_en is asserted with an out-of-range address (write dropped)
module matrix_wr_bank
  import matmul_load_ctrl_pkg::*;
#(
  parameter int MATRIX_N = 3,
  parameter int MATRIX_M = 3,
  parameter int WIDTH    = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_en,
  input  logic [idx_w(MATRIX_N)-1:0]         wr_row,
  input  logic [idx_w(MATRIX_M)-1:0]         wr_col,
  input  logic [WIDTH-1:0]                   wr_data,
  output logic [MATRIX_N*MATRIX_M*WIDTH-1:0] flat,
  output logic                               addr_err
);

  logic in_range;

  // Index widths are rounded up to a power of two, so e.g. row 3 is encodable for N=3.
  assign in_range = (int'(wr_row) < MATRIX_N) && (int'(wr_col) < MATRIX_M);
  assign addr_err = wr_en && !in_range;

  // NOTE: this array is small and downstream logic must see zeros after reset, so it is
  // reset like any control register; large RAM-style arrays would normally be left unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flat <= '0;
    end else if (wr_en && in_range) begin
      flat[elem_lsb(int'(wr_row), int'(wr_col), MATRIX_M, WIDTH) +: WIDTH] <= wr_data;
    end
  end

endmodule

// File: rtl/matmul_load_ctrl.sv
// matmul_load_ctrl: loads operand matrices A and B element-serially into shadow banks,
// commits them to the flat buses feeding the display/compute block, and runs the
// read_ready/compute_done handshake. Shadow banks stay writable in every state, so the
// next operand pair can be loaded while the current pair is being computed.
//  clk, reset     : clock, asynchronous active-low reset
//  wr_en/sel/row/col/data : element write port (sel 0 = A, 1 = B)
//  go             : 1-cycle request to commit shadow banks and start a compute
//  compute_done   : level from the compute block, high when the result is ready
//  matrix_a/b     : active operand buses, change only on the commit edge
//  read_ready     : operands valid, compute requested
//  busy           : FSM not idle
//  done           : 1-cycle pulse when compute_done is accepted
//  err            : sticky [0] addr range, [1] go while busy, [2] timeout; cleared by an accepted go
module matmul_load_ctrl
  import matmul_load_ctrl_pkg::*;
#(
  parameter int MATRIX_N    = 3,
  parameter int MATRIX_M    = 3,
  parameter int WIDTH       = 16,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_en,
  input  logic                               wr_sel,
  input  logic [idx_w(MATRIX_N)-1:0]         wr_row,
  input  logic [idx_w(MATRIX_M)-1:0]         wr_col,
  input  logic [WIDTH-1:0]                   wr_data,
  input  logic                               go,
  input  logic                               compute_done,
  output logic [MATRIX_N*MATRIX_M*WIDTH-1:0] matrix_a,
  output logic [MATRIX_N*MATRIX_M*WIDTH-1:0] matrix_b,
  output logic                               read_ready,
  output logic                               busy,
  output logic                               done,
  output logic [2:0]                         err
);

  localparam int BUS_W = MATRIX_N * MATRIX_M * WIDTH;
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [BUS_W-1:0] shadow_a, shadow_b;
  logic             addr_err_a, addr_err_b;
  logic [2:0]       err_next;
  logic             timeout_hit;

  matrix_wr_bank #(.MATRIX_N(MATRIX_N), .MATRIX_M(MATRIX_M), .WIDTH(WIDTH)) u_bank_a (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en && !wr_sel),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .flat     (shadow_a),
    .addr_err (addr_err_a)
  );

  matrix_wr_bank #(.MATRIX_N(MATRIX_N), .MATRIX_M(MATRIX_M), .WIDTH(WIDTH)) u_bank_b (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en && wr_sel),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .flat     (shadow_b),
    .addr_err (addr_err_b)
  );

  assign read_ready  = (state == ST_REQ);
  assign busy        = (state != ST_IDLE);
  assign timeout_hit = (state == ST_REQ) && !compute_done && (cnt == CNT_LAST);

  // An accepted go wipes the sticky bits, but an event on that same edge still records.
  // NOTE: every output of this block gets a value before any condition, so no latch is inferred.
  always_comb begin
    err_next = err;
    if (state == ST_IDLE && go) err_next = '0;
    if (addr_err_a || addr_err_b)   err_next[ERR_ADDR]    = 1'b1;
    if (go && state != ST_IDLE)     err_next[ERR_GO_BUSY] = 1'b1;
    if (timeout_hit)                err_next[ERR_TIMEOUT] = 1'b1;
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values;
  // this is what lets a same-edge shadow write and commit give the old value to active.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      matrix_a <= '0;
      matrix_b <= '0;
      done     <= 1'b0;
      err      <= '0;
    end else begin
      done <= 1'b0;
      err  <= err_next;
      case (state)
        ST_IDLE: begin
          if (go) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          matrix_a <= shadow_a;
          matrix_b <= shadow_b;
          cnt      <= '0;
          state    <= ST_REQ;
        end
        ST_REQ: begin
          if (compute_done) begin
            done  <= 1'b1;
            state <= ST_DRAIN;
          end else if (cnt == CNT_LAST) begin
            state <= ST_DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin  // ST_DRAIN: wait for the compute block to drop its result flag
          if (!compute_done) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_load_ctrl.sv
module tb_matmul_load_ctrl;

  localparam int N     = 3;
  localparam int M     = 3;
  localparam int W     = 16;
  localparam int TO    = 16;
  localparam int BUS_W = N * M * W;

  typedef struct packed {
    logic [BUS_W-1:0] a;
    logic [BUS_W-1:0] b;
  } pair_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             wr_en = 1'b0, wr_sel = 1'b0;
  logic [1:0]       wr_row = '0, wr_col = '0;
  logic [W-1:0]     wr_data = '0;
  logic             go = 1'b0, compute_done = 1'b0;
  logic [BUS_W-1:0] matrix_a, matrix_b;
  logic             read_ready, busy, done;
  logic [2:0]       err;

  int passed = 0;
  int total  = 0;

  logic [W-1:0]     ma [N][M];
  logic [W-1:0]     mb [N][M];
  logic [BUS_W-1:0] act_a = '0, act_b = '0;
  pair_t            exp_q [$];

  matmul_load_ctrl #(.MATRIX_N(N), .MATRIX_M(M), .WIDTH(W), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .wr_row       (wr_row),
    .wr_col       (wr_col),
    .wr_data      (wr_data),
    .go           (go),
    .compute_done (compute_done),
    .matrix_a     (matrix_a),
    .matrix_b     (matrix_b),
    .read_ready   (read_ready),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required one");
    $fatal(1, "watchdog");
  end

  function automatic logic [BUS_W-1:0] pack(input bit sel);
    logic [BUS_W-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < M; c++)
        v[(r*M+c)*W +: W] = sel ? mb[r][c] : ma[r][c];
    return v;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < M; c++) begin
        ma[r][c] = '0;
        mb[r][c] = '0;
      end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_elem(input bit sel, input int row, input int col, input logic [W-1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_row = 2'(row); wr_col = 2'(col); wr_data = d;
    if (row < N && col < M) begin
      if (sel) mb[row][col] = d; else ma[row][col] = d;
    end
    step();
    wr_en = 1'b0;
  endtask

  // go -> COMMIT (matrices still old) -> REQ (matrices = snapshot at go, read_ready high).
  task automatic start_op(input string tag);
    pair_t e;
    exp_q.push_back('{a: pack(1'b0), b: pack(1'b1)});
    go = 1'b1;
    step();
    go = 1'b0;
    total++;
    if (busy !== 1'b1 || read_ready !== 1'b0 || matrix_a !== act_a || matrix_b !== act_b)
      $display("FAIL %s commit_cycle: busy=%b rr=%b a=%h b=%h, required busy=1 rr=0 a=%h b=%h",
               tag, busy, read_ready, matrix_a, matrix_b, act_a, act_b);
    else passed++;
    step();
    total++;
    if (read_ready !== 1'b1) $display("FAIL %s read_ready_t2: got %b, required 1", tag, read_ready);
    else passed++;
    e = exp_q.pop_front();
    total++;
    if (matrix_a !== e.a) $display("FAIL %s matrix_a: got %h, required %h", tag, matrix_a, e.a);
    else passed++;
    total++;
    if (matrix_b !== e.b) $display("FAIL %s matrix_b: got %h, required %h", tag, matrix_b, e.b);
    else passed++;
    act_a = e.a;
    act_b = e.b;
  endtask

  task automatic finish_op(input string tag);
    compute_done = 1'b1;
    step();
    total++;
    if (done !== 1'b1 || read_ready !== 1'b0)
      $display("FAIL %s done_pulse: done=%b rr=%b, required done=1 rr=0", tag, done, read_ready);
    else passed++;
    compute_done = 1'b0;
    step();
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL %s back_idle: busy=%b done=%b, required 0 0", tag, busy, done);
    else passed++;
  endtask

  task automatic test_reset();
    clear_model();
    reset = 1'b0;
    repeat (2) step();
    total++;
    if (matrix_a !== '0 || matrix_b !== '0 || read_ready !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || err !== 3'b000)
      $display("FAIL reset_state: a=%h b=%h rr=%b busy=%b done=%b err=%b, required all zero",
               matrix_a, matrix_b, read_ready, busy, done, err);
    else passed++;
    #2 reset = 1'b1;
    step();
  endtask

  task automatic test_load();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < M; c++) write_elem(1'b0, r, c, W'(r*M + c + 1));
    for (int r = 0; r < N; r++)
      for (int c = 0; c < M; c++) write_elem(1'b1, r, c, W'(9 - (r*M + c)));
    start_op("load");
    total++;
    if (matrix_a !== 144'h0009_0008_0007_0006_0005_0004_0003_0002_0001)
      $display("FAIL load_packing: got %h, required 0009..0001", matrix_a);
    else passed++;
  endtask

  task automatic test_done();
    int pulses;
    pulses = 0;
    repeat (2) begin
      step();
      total++;
      if (read_ready !== 1'b1 || done !== 1'b0)
        $display("FAIL done_wait: rr=%b done=%b, required rr=1 done=0", read_ready, done);
      else passed++;
    end
    compute_done = 1'b1;
    step();
    if (done === 1'b1) pulses++;
    total++;
    if (read_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL done_drain: rr=%b busy=%b, required rr=0 busy=1", read_ready, busy);
    else passed++;
    step();
    if (done === 1'b1) pulses++;
    total++;
    if (busy !== 1'b1) $display("FAIL done_hold: busy=%b, required 1 while compute_done high", busy);
    else passed++;
    compute_done = 1'b0;
    step();
    if (done === 1'b1) pulses++;
    total++;
    if (pulses != 1) $display("FAIL done_pulse_count: got %0d, required 1", pulses);
    else passed++;
    total++;
    if (busy !== 1'b0 || err !== 3'b000)
      $display("FAIL done_idle: busy=%b err=%b, required busy=0 err=000", busy, err);
    else passed++;
  endtask

  task automatic test_addr_err();
    write_elem(1'b0, 3, 0, 16'hDEAD);
    total++;
    if (err !== 3'b001 || matrix_a !== act_a)
      $display("FAIL addr_row3: err=%b a=%h, required err=001 a=%h", err, matrix_a, act_a);
    else passed++;
    write_elem(1'b1, 0, 3, 16'hDEAD);
    total++;
    if (err !== 3'b001) $display("FAIL addr_col3: err=%b, required 001", err);
    else passed++;
    start_op("addr");
    total++;
    if (err !== 3'b000) $display("FAIL addr_clear_on_go: err=%b, required 000", err);
    else passed++;
    finish_op("addr");
  endtask

  task automatic test_go_busy();
    start_op("gobusy");
    go = 1'b1;
    step();
    go = 1'b0;
    total++;
    if (err !== 3'b010 || read_ready !== 1'b1 || matrix_a !== act_a)
      $display("FAIL go_in_req: err=%b rr=%b a=%h, required err=010 rr=1 a=%h",
               err, read_ready, matrix_a, act_a);
    else passed++;
    write_elem(1'b1, 0, 0, 16'hBEEF);
    total++;
    if (matrix_b !== act_b) $display("FAIL shadow_write_req: b=%h, required %h", matrix_b, act_b);
    else passed++;
    finish_op("gobusy");
    total++;
    if (matrix_b !== act_b) $display("FAIL b_held_idle: b=%h, required %h", matrix_b, act_b);
    else passed++;
    start_op("beef");
    total++;
    if (matrix_b[15:0] !== 16'hBEEF) $display("FAIL beef_commit: got %h, required beef", matrix_b[15:0]);
    else passed++;
    finish_op("beef");
  endtask

  task automatic test_timeout();
    int  hi;
    bit  done_seen;
    hi = 1;
    done_seen = 1'b0;
    start_op("timeout");
    for (int i = 0; i < 40; i++) begin
      step();
      if (done === 1'b1) done_seen = 1'b1;
      if (read_ready !== 1'b1) break;
      hi++;
    end
    total++;
    if (hi != TO) $display("FAIL timeout_len: read_ready high %0d cycles, required %0d", hi, TO);
    else passed++;
    total++;
    if (err !== 3'b100 || done_seen)
      $display("FAIL timeout_err: err=%b done_seen=%b, required err=100 done_seen=0", err, done_seen);
    else passed++;
    step();
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL timeout_idle: busy=%b done=%b, required 0 0", busy, done);
    else passed++;
  endtask

  task automatic test_reset_mid();
    pair_t e;
    start_op("pre_reset");
    step();
    reset = 1'b0;
    #1;
    total++;
    if (matrix_a !== '0 || matrix_b !== '0 || read_ready !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || err !== 3'b000)
      $display("FAIL reset_mid: a=%h b=%h rr=%b busy=%b done=%b err=%b, required all zero",
               matrix_a, matrix_b, read_ready, busy, done, err);
    else passed++;
    #2 reset = 1'b1;
    clear_model();
    act_a = '0;
    act_b = '0;
    step();
    write_elem(1'b0, 1, 1, 16'h1111);
    // go, then a write to the same element during the COMMIT cycle.
    exp_q.push_back('{a: pack(1'b0), b: pack(1'b1)});
    go = 1'b1;
    step();
    go = 1'b0;
    wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd1; wr_col = 2'd1; wr_data = 16'h2222;
    ma[1][1] = 16'h2222;
    step();
    wr_en = 1'b0;
    total++;
    if (read_ready !== 1'b1) $display("FAIL samecycle_rr: got %b, required 1", read_ready);
    else passed++;
    e = exp_q.pop_front();
    total++;
    if (matrix_a !== e.a || matrix_b !== e.b)
      $display("FAIL samecycle_commit: a=%h b=%h, required a=%h b=%h", matrix_a, matrix_b, e.a, e.b);
    else passed++;
    act_a = e.a;
    act_b = e.b;
    finish_op("samecycle");
    start_op("after_samecycle");
    total++;
    if (matrix_a[4*W +: W] !== 16'h2222)
      $display("FAIL samecycle_next: got %h, required 2222", matrix_a[4*W +: W]);
    else passed++;
    finish_op("after_samecycle");
  endtask

  initial begin
    test_reset();
    test_load();
    test_done();
    test_addr_err();
    test_go_busy();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
